// File: rtl/egm_mon_pkg.sv
// Shared types and default constants for the EGM stimulus/response latency monitor.
package egm_mon_pkg;

  // Measurement FSM: idle until a stimulus edge, then waiting for the response edge.
  typedef enum logic {
    StIdle,
    StWaitResp
  } egm_state_e;

  // One latency tick is 1 us at a 50 MHz system clock.
  localparam int unsigned DEF_TICK_DIV = 50;
  // Ticks without a response before the measurement is abandoned as a miss.
  localparam int unsigned DEF_TIMEOUT  = 10000;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer for an asynchronous line followed by a registered rising-edge pulse.
module sync_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic [1:0] r_sync;
  logic       r_prev;
  logic       r_rise;

  // Synchronize the line, remember last synchronized level, emit one-cycle pulse on 0->1.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
      r_prev <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_sync[1];
      r_rise <= r_sync[1] & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/egm_latency_monitor.sv
// Observes the EGM stimulus and response PIO lines and measures stimulus-to-response
// latency in ticks, keeping last/min/max plus saturating sample and miss counters.
module egm_latency_monitor
  import egm_mon_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter int unsigned MISS_W   = 8
) (
  input  logic              clk_50_clk,
  input  logic              reset_reset_n,
  input  logic              stimulus,
  input  logic              response,
  input  logic              clear,
  output logic              busy,
  output logic              result_valid,
  output logic [CNT_W-1:0]  last_latency,
  output logic [CNT_W-1:0]  min_latency,
  output logic [CNT_W-1:0]  max_latency,
  output logic [15:0]       sample_count,
  output logic [MISS_W-1:0] miss_count
);

  localparam int unsigned      PresW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresMax      = PresW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] TimeoutTicks = CNT_W'(TIMEOUT);

  egm_state_e        r_state;
  logic              r_busy;
  logic              r_valid;
  logic [PresW-1:0]  r_presc;
  logic [CNT_W-1:0]  r_ticks;
  logic [CNT_W-1:0]  r_last;
  logic [CNT_W-1:0]  r_min;
  logic [CNT_W-1:0]  r_max;
  logic [15:0]       r_samples;
  logic [MISS_W-1:0] r_misses;

  logic              w_stim_rise;
  logic              w_resp_rise;
  logic              w_presc_wrap;
  logic [CNT_W-1:0]  w_ticks_now;
  logic [CNT_W-1:0]  w_min_nxt;
  logic [CNT_W-1:0]  w_max_nxt;

  // Both lines share an identical synchronizer so the path delay cancels in the latency.
  sync_edge_det u_stim_det (
    .i_clk   (clk_50_clk),
    .i_rst_n (reset_reset_n),
    .i_async (stimulus),
    .o_rise  (w_stim_rise)
  );

  sync_edge_det u_resp_det (
    .i_clk   (clk_50_clk),
    .i_rst_n (reset_reset_n),
    .i_async (response),
    .o_rise  (w_resp_rise)
  );

  // Tick count including the wrap happening on this very cycle, so a response N cycles
  // after the stimulus records floor(N / TICK_DIV).
  always_comb begin
    w_presc_wrap = (r_presc == PresMax);
    w_ticks_now  = r_ticks + CNT_W'(w_presc_wrap);
    w_min_nxt    = (w_ticks_now < r_min) ? w_ticks_now : r_min;
    w_max_nxt    = (w_ticks_now > r_max) ? w_ticks_now : r_max;
  end

  // Measurement FSM with statistics; clear overrides every edge event.
  always_ff @(posedge clk_50_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state   <= StIdle;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_presc   <= '0;
      r_ticks   <= '0;
      r_last    <= '0;
      r_min     <= '1;
      r_max     <= '0;
      r_samples <= '0;
      r_misses  <= '0;
    end else begin
      r_valid <= 1'b0;
      if (clear) begin
        r_state   <= StIdle;
        r_busy    <= 1'b0;
        r_presc   <= '0;
        r_ticks   <= '0;
        r_last    <= '0;
        r_min     <= '1;
        r_max     <= '0;
        r_samples <= '0;
        r_misses  <= '0;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_stim_rise) begin
              r_state <= StWaitResp;
              r_busy  <= 1'b1;
              r_presc <= '0;
              r_ticks <= '0;
            end
          end
          StWaitResp: begin
            if (w_resp_rise) begin
              // Response beats both overrun and timeout on the same cycle.
              r_last  <= w_ticks_now;
              r_min   <= w_min_nxt;
              r_max   <= w_max_nxt;
              r_valid <= 1'b1;
              if (r_samples != 16'hFFFF) r_samples <= r_samples + 16'd1;
              r_presc <= '0;
              r_ticks <= '0;
              if (!w_stim_rise) begin
                r_state <= StIdle;
                r_busy  <= 1'b0;
              end
            end else if (w_stim_rise) begin
              // Overrun: a new stimulus before any response restarts the measurement.
              if (r_misses != '1) r_misses <= r_misses + MISS_W'(1);
              r_presc <= '0;
              r_ticks <= '0;
            end else if (r_ticks == TimeoutTicks) begin
              if (r_misses != '1) r_misses <= r_misses + MISS_W'(1);
              r_state <= StIdle;
              r_busy  <= 1'b0;
              r_presc <= '0;
              r_ticks <= '0;
            end else if (w_presc_wrap) begin
              r_presc <= '0;
              r_ticks <= r_ticks + CNT_W'(1);
            end else begin
              r_presc <= r_presc + PresW'(1);
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign last_latency = r_last;
  assign min_latency  = r_min;
  assign max_latency  = r_max;
  assign sample_count = r_samples;
  assign miss_count   = r_misses;

endmodule

// File: tb/tb_egm_latency_monitor.sv
// Scoreboard bench for egm_latency_monitor with TICK_DIV=5, TIMEOUT=100.
module tb_egm_latency_monitor;

  logic        clk;
  logic        rst_n;
  logic        stimulus;
  logic        response;
  logic        clear;
  logic        busy;
  logic        result_valid;
  logic [15:0] last_latency;
  logic [15:0] min_latency;
  logic [15:0] max_latency;
  logic [15:0] sample_count;
  logic [7:0]  miss_count;

  typedef struct packed {
    logic [15:0] last;
    logic [15:0] mn;
    logic [15:0] mx;
    logic [15:0] samples;
    logic [7:0]  misses;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  egm_latency_monitor #(
    .CNT_W    (16),
    .TICK_DIV (5),
    .TIMEOUT  (100),
    .MISS_W   (8)
  ) dut (
    .clk_50_clk    (clk),
    .reset_reset_n (rst_n),
    .stimulus      (stimulus),
    .response      (response),
    .clear         (clear),
    .busy          (busy),
    .result_valid  (result_valid),
    .last_latency  (last_latency),
    .min_latency   (min_latency),
    .max_latency   (max_latency),
    .sample_count  (sample_count),
    .miss_count    (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stats(input string tag, input exp_t e);
    check({tag, ".last"}, int'(last_latency), int'(e.last));
    check({tag, ".min"}, int'(min_latency), int'(e.mn));
    check({tag, ".max"}, int'(max_latency), int'(e.mx));
    check({tag, ".samples"}, int'(sample_count), int'(e.samples));
    check({tag, ".misses"}, int'(miss_count), int'(e.misses));
  endtask

  function automatic exp_t mk(int l, int mn, int mx, int s, int m);
    exp_t e;
    e.last    = 16'(l);
    e.mn      = 16'(mn);
    e.mx      = 16'(mx);
    e.samples = 16'(s);
    e.misses  = 8'(m);
    return e;
  endfunction

  // Monitor: every result_valid pulse must match the oldest expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (result_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got last=%0d expected no result", last_latency);
        end else begin
          e = q.pop_front();
          check_stats("result", e);
          check("result.busy_low", int'(busy), 0);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle(2);
  endtask

  // Stimulus rise, response rise n cycles later, both released afterwards.
  task automatic run_loop(input int n);
    @(negedge clk);
    stimulus = 1'b1;
    idle(n);
    response = 1'b1;
    idle(8);
    stimulus = 1'b0;
    response = 1'b0;
    idle(4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    stimulus = 1'b0;
    response = 1'b0;
    clear    = 1'b0;
    idle(3);
    check_stats("reset", mk(0, 16'hFFFF, 0, 0, 0));
    check("reset.busy", int'(busy), 0);
    check("reset.valid", int'(result_valid), 0);
    rst_n = 1'b1;
    idle(3);

    // 1: single 50-cycle loop
    q.push_back(mk(10, 10, 10, 1, 0));
    run_loop(50);
    check("t1.busy", int'(busy), 0);

    // 2: three loops from cleared stats
    pulse_clear();
    check_stats("t2.cleared", mk(0, 16'hFFFF, 0, 0, 0));
    q.push_back(mk(5, 5, 5, 1, 0));
    run_loop(25);
    q.push_back(mk(12, 5, 12, 2, 0));
    run_loop(60);
    q.push_back(mk(8, 5, 12, 3, 0));
    run_loop(40);

    // 3: no response -> timeout after 100 ticks
    @(negedge clk);
    stimulus = 1'b1;
    idle(20);
    check("t3.busy_mid", int'(busy), 1);
    idle(478);
    check("t3.miss_before_timeout", int'(miss_count), 0);
    idle(12);
    check("t3.busy_after", int'(busy), 0);
    check_stats("t3", mk(8, 5, 12, 3, 1));
    stimulus = 1'b0;
    idle(4);

    // 4: overrun then response 20 cycles after the second stimulus
    pulse_clear();
    @(negedge clk);
    stimulus = 1'b1;
    idle(10);
    stimulus = 1'b0;
    idle(20);
    stimulus = 1'b1;
    idle(20);
    response = 1'b1;
    q.push_back(mk(4, 4, 4, 1, 1));
    idle(8);
    stimulus = 1'b0;
    response = 1'b0;
    idle(4);
    check("t4.miss", int'(miss_count), 1);

    // 5: clear mid-measurement, later response ignored
    @(negedge clk);
    stimulus = 1'b1;
    idle(20);
    check("t5.busy_mid", int'(busy), 1);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    idle(10);
    response = 1'b1;
    idle(10);
    check_stats("t5", mk(0, 16'hFFFF, 0, 0, 0));
    check("t5.busy", int'(busy), 0);
    stimulus = 1'b0;
    response = 1'b0;
    idle(4);

    // 6: async reset mid-measurement, then a 15-cycle loop
    q.push_back(mk(6, 6, 6, 1, 0));
    run_loop(30);
    @(negedge clk);
    stimulus = 1'b1;
    idle(20);
    check("t6.busy_mid", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_stats("t6.async", mk(0, 16'hFFFF, 0, 0, 0));
    check("t6.async_busy", int'(busy), 0);
    check("t6.async_valid", int'(result_valid), 0);
    stimulus = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(3);
    q.push_back(mk(3, 3, 3, 1, 0));
    run_loop(15);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    check("pending_results", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
